key_event: RTL

KEY_EVENT -- requirements
Module: key_event

---
 rtl/key_event.sv | 109 ++++++++++
 1 files changed

// File: rtl/key_event.sv
// ============================================================================
// Module  : key_event
// Brief   : Per-key press / click / long-press / auto-repeat event generator
//           for three debounced, active-low keys.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module key_event #(
  parameter int LONG_TIME   = 25_000_000,
  parameter int REPEAT_TIME = 5_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] key_value,
  output logic [2:0] key_press,
  output logic [2:0] key_click,
  output logic [2:0] key_long,
  output logic [2:0] key_rpt,
  output logic [2:0] key_hold
);

  localparam logic [31:0] C_LONG_LAST = 32'(LONG_TIME - 1);
  localparam logic [31:0] C_RPT_LAST  = 32'(REPEAT_TIME - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PRESS  = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

  for (genvar gi = 0; gi < 3; gi++) begin : g_key
    state_t      r_state;
    logic [31:0] r_cnt;
    logic        r_press;
    logic        r_click;
    logic        r_long;
    logic        r_rpt;
    logic        r_hold;

    // Release always takes priority over a threshold reached on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= S_IDLE;
        r_cnt   <= 32'd0;
        r_press <= 1'b0;
        r_click <= 1'b0;
        r_long  <= 1'b0;
        r_rpt   <= 1'b0;
        r_hold  <= 1'b0;
      end else begin
        r_press <= 1'b0;
        r_click <= 1'b0;
        r_long  <= 1'b0;
        r_rpt   <= 1'b0;
        case (r_state)
          S_IDLE: begin
            if (!key_value[gi]) begin
              r_state <= S_PRESS;
              r_cnt   <= 32'd0;
              r_press <= 1'b1;
              r_hold  <= 1'b1;
            end
          end
          S_PRESS: begin
            if (key_value[gi]) begin
              r_state <= S_IDLE;
              r_cnt   <= 32'd0;
              r_click <= 1'b1;
              r_hold  <= 1'b0;
            end else if (r_cnt == C_LONG_LAST) begin
              r_state <= S_REPEAT;
              r_cnt   <= 32'd0;
              r_long  <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 32'd1;
            end
          end
          S_REPEAT: begin
            if (key_value[gi]) begin
              r_state <= S_IDLE;
              r_cnt   <= 32'd0;
              r_hold  <= 1'b0;
            end else if (r_cnt == C_RPT_LAST) begin
              r_cnt <= 32'd0;
              r_rpt <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 32'd1;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_cnt   <= 32'd0;
            r_hold  <= 1'b0;
          end
        endcase
      end
    end

    assign key_press[gi] = r_press;
    assign key_click[gi] = r_click;
    assign key_long[gi]  = r_long;
    assign key_rpt[gi]   = r_rpt;
    assign key_hold[gi]  = r_hold;
  end

endmodule

`default_nettype wire
